la_readout_serializer: RTL and testbench
========================================

// Module: la_readout_serializer
// PURPOSE
//   Downstream readout stage for the logic analyzer capture buffer. After a capture
//   completes, walks the buffer read bus from address 0 to DEPTH-1 and serialises
//   every sample word into a byte stream with a valid/ready handshake.
//   Frame format: header 0xA5, then each word MSB byte first, then a trailer byte
//   equal to the XOR of all data bytes. The byte stream feeds the host UART TX.
// PARAMETERS
//   DATA_WIDTH    128  capture word width; must be a multiple of 8
//   ADDR_WIDTH    9    read address width
//   DEPTH         512  words to dump; 1 <= DEPTH <= 2**ADDR_WIDTH
//   READ_LATENCY  1    cycles from read_addr change to valid read_data; 1..4
// PORTS
//   clk           in   1           system clock; capture buffer read side on same clock
//   rst           in   1           synchronous reset, active-high
//   capture_done  in   1           level; high when the buffer holds a finished capture
//   start         in   1           one-cycle request to begin a dump
//   read_addr     out  ADDR_WIDTH  capture buffer read address
//   read_data     in   DATA_WIDTH  capture buffer read data, READ_LATENCY after read_addr
//   tx_data       out  8           byte to host link
//   tx_valid      out  1           tx_data valid
//   tx_ready      in   1           sink accepts the byte this cycle
//   busy          out  1           high from accepted start until done
//   done          out  1           one-cycle pulse after the trailer byte is accepted
// BEHAVIOUR
//   Reset values: read_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, state=IDLE.
//   Transfer: a byte moves on any cycle where tx_valid && tx_ready. While tx_valid is
//     high, tx_data holds stable and tx_valid stays high until accepted. There is no
//     combinational path from tx_ready to tx_valid.
//   FSM:
//   - IDLE: if start && capture_done, clear checksum and addr, set busy, go to HEADER.
//     If start && !capture_done, ignore start and stay in IDLE.
//   - HEADER: present 0xA5. On accept, drive read_addr=addr and go to WAIT.
//   - WAIT: count READ_LATENCY cycles, latch read_data into the shift register,
//     set byte_idx=0, then go to SEND.
//   - SEND: present shift[DATA_WIDTH-1 -: 8]. On accept:
//     - XOR the byte into the checksum and shift the register left by 8.
//     - After byte DATA_WIDTH/8-1: if addr==DEPTH-1 go to TRAILER; otherwise
//       increment addr, drive read_addr, and go to WAIT.
//   - TRAILER: present the checksum byte. On accept, pulse done, clear busy, go to IDLE.
//   No address wrap: the dump ends after DEPTH-1, and read_addr holds its last value
//     until the next start.
//   Throughput: with tx_ready held high, one word costs READ_LATENCY + DATA_WIDTH/8
//     cycles. Total frame = 2 + DEPTH*DATA_WIDTH/8 bytes.
//   start while busy: ignored and not queued.
//   capture_done dropping mid-dump: ignored; the dump finishes.
//   tx_ready stalls of any length: no byte is lost or duplicated, and read_addr does
//     not advance.
//   rst mid-dump: on the next edge, return to IDLE with tx_valid=0 and busy=0; the
//     partial frame is abandoned and done does not pulse.
//   done and a new start in the same cycle: the start is ignored, because busy is
//     still high in that cycle.
// STRUCTURE
//   Shared package: localparam FRAME_HEADER=8'hA5; state enum {IDLE, HEADER, WAIT,
//     SEND, TRAILER}; BYTES_PER_WORD=DATA_WIDTH/8.
//   Single module plus one sub-module, la_word_shifter: a parallel-load, shift-by-8
//     register with a byte counter and a last_byte flag. The FSM, address counter,
//     and checksum live in the top module.
// TESTING
//   1. DEPTH=4, memory model word k = {16{8'h10+k}}, tx_ready=1, start with
//      capture_done=1. Expect 66 bytes: A5, 16x10, 16x11, 16x12, 16x13, trailer 00.
//      done pulses once, and busy is high for the whole frame.
//   2. Same setup with tx_ready toggling pseudo-randomly (~30% stall). Expect an
//      identical byte sequence; tx_data is stable during every stall, and read_addr
//      changes only after the last byte of a word is accepted.
//   3. start with capture_done=0. Expect tx_valid=0 and busy=0 for 50 cycles.
//      Pulse start 3 more times during a dump; expect exactly one frame and one done.
//   4. Assert rst for 1 cycle after byte 20 is accepted. Expect tx_valid=0, busy=0,
//      read_addr=0 next cycle and no done pulse. A fresh start then yields a full
//      correct frame.
//   5. READ_LATENCY=3, words 0x0123..EF (distinct bytes). Expect the correct byte
//      order and checksum equal to the XOR of all 64 data bytes. Read data must not
//      be sampled before the 3-cycle latency elapses.
//   6. DEPTH=512, ADDR_WIDTH=9. Expect the final word read at address 511, no wrap
//      to 0, and a frame length of 8194 bytes.

Source files
------------

// File: rtl/la_readout_serializer_pkg.sv
// ============================================================================
// Module      : la_readout_serializer_pkg
// Description : Shared frame constants, FSM state type and sizing helper for
//               the capture-buffer readout serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package la_readout_serializer_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        WAIT    = 3'd2,
        SEND    = 3'd3,
        TRAILER = 3'd4
    } state_t;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/la_readout_serializer_word_shifter.sv
// ============================================================================
// Module      : la_word_shifter
// Description : Parallel-load, shift-left-by-8 word register with byte counter
//               and last-byte flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module la_word_shifter
    import la_readout_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    output logic [7:0]            o_next_byte,
    output logic                  o_last_byte
);

    localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
    localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_byte_idx;
    logic [DATA_WIDTH-1:0] w_shifted;

    // The byte that becomes the head after the current head is consumed.
    assign w_shifted   = r_shift << 8;
    assign o_next_byte = w_shifted[DATA_WIDTH-1 -: 8];
    assign o_last_byte = (r_byte_idx == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
        end else if (i_load) begin
            r_shift    <= i_data;
            r_byte_idx <= '0;
        end else if (i_shift) begin
            r_shift    <= w_shifted;
            r_byte_idx <= r_byte_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/la_readout_serializer.sv
// ============================================================================
// Module      : la_readout_serializer
// Description : Dumps the capture buffer as a framed byte stream
//               (header, words MSB-first, XOR checksum) over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module la_readout_serializer
    import la_readout_serializer_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int ADDR_WIDTH   = 9,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_capture_done,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_read_addr,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_csum;
    logic [LAT_W-1:0]      r_lat_cnt;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_shift;
    logic [7:0]            w_next_byte;
    logic                  w_last_byte;

    assign w_accept = o_tx_valid && i_tx_ready;
    assign w_load   = (r_state == WAIT) && (r_lat_cnt == LAT_W'(READ_LATENCY - 1));
    assign w_shift  = (r_state == SEND) && w_accept;

    la_word_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_shifter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_data      (i_read_data),
        .i_shift     (w_shift),
        .o_next_byte (w_next_byte),
        .o_last_byte (w_last_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_csum      <= '0;
            r_lat_cnt   <= '0;
            o_read_addr <= '0;
            o_tx_data   <= '0;
            o_tx_valid  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy lingers through the done cycle so a start there is dropped
                    o_busy <= 1'b0;
                    if (i_start && i_capture_done && !o_busy) begin
                        r_csum     <= '0;
                        r_addr     <= '0;
                        o_busy     <= 1'b1;
                        o_tx_data  <= FRAME_HEADER;
                        o_tx_valid <= 1'b1;
                        r_state    <= HEADER;
                    end
                end
                HEADER: begin
                    if (w_accept) begin
                        o_tx_valid  <= 1'b0;
                        o_read_addr <= r_addr;
                        r_lat_cnt   <= '0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_load) begin
                        o_tx_data  <= i_read_data[DATA_WIDTH-1 -: 8];
                        o_tx_valid <= 1'b1;
                        r_state    <= SEND;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ o_tx_data;
                        if (!w_last_byte) begin
                            o_tx_data <= w_next_byte;
                        end else if (r_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                            o_tx_data <= r_csum ^ o_tx_data;
                            r_state   <= TRAILER;
                        end else begin
                            r_addr      <= r_addr + 1'b1;
                            o_read_addr <= r_addr + 1'b1;
                            o_tx_valid  <= 1'b0;
                            r_lat_cnt   <= '0;
                            r_state     <= WAIT;
                        end
                    end
                end
                TRAILER: begin
                    if (w_accept) begin
                        o_tx_valid <= 1'b0;
                        o_done     <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_la_readout_serializer.sv
// ============================================================================
// Module      : tb_la_readout_serializer
// Description : Self-checking bench: two serializer instances (short/slow read
//               and full-depth) checked against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_la_readout_serializer;

    localparam int DW      = 128;
    localparam int BPW     = DW / 8;
    localparam int A_DEPTH = 4;
    localparam int A_AW    = 2;
    localparam int A_RL    = 3;
    localparam int B_DEPTH = 512;
    localparam int B_AW    = 9;
    localparam int B_RL    = 1;

    typedef logic [7:0]    byte_q_t[$];
    typedef logic [DW-1:0] word_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: short buffer, 3-cycle read latency
    logic            a_capture_done = 1'b0;
    logic            a_start        = 1'b0;
    logic            a_ready        = 1'b1;
    logic [A_AW-1:0] a_read_addr;
    logic [DW-1:0]   a_read_data;
    logic [7:0]      a_tx_data;
    logic            a_tx_valid, a_busy, a_done;

    // Instance B: full 512-word buffer, 1-cycle read latency
    logic            b_capture_done = 1'b0;
    logic            b_start        = 1'b0;
    logic            b_ready        = 1'b1;
    logic [B_AW-1:0] b_read_addr;
    logic [DW-1:0]   b_read_data;
    logic [7:0]      b_tx_data;
    logic            b_tx_valid, b_busy, b_done;

    logic [DW-1:0]   mem_a [A_DEPTH];
    logic [DW-1:0]   mem_b [B_DEPTH];
    logic [A_AW-1:0] a_pipe1, a_pipe2;

    always @(posedge clk) begin
        a_pipe1 <= a_read_addr;
        a_pipe2 <= a_pipe1;
    end
    assign a_read_data = mem_a[a_pipe2];
    assign b_read_data = mem_b[b_read_addr];

    la_readout_serializer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(A_AW), .DEPTH(A_DEPTH), .READ_LATENCY(A_RL)
    ) u_dut_a (
        .clk(clk), .rst(rst), .i_capture_done(a_capture_done), .i_start(a_start),
        .o_read_addr(a_read_addr), .i_read_data(a_read_data), .o_tx_data(a_tx_data),
        .o_tx_valid(a_tx_valid), .i_tx_ready(a_ready), .o_busy(a_busy), .o_done(a_done)
    );

    la_readout_serializer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(B_AW), .DEPTH(B_DEPTH), .READ_LATENCY(B_RL)
    ) u_dut_b (
        .clk(clk), .rst(rst), .i_capture_done(b_capture_done), .i_start(b_start),
        .o_read_addr(b_read_addr), .i_read_data(b_read_data), .o_tx_data(b_tx_data),
        .o_tx_valid(b_tx_valid), .i_tx_ready(b_ready), .o_busy(b_busy), .o_done(b_done)
    );

    // ------------------------------------------------------------ sink side
    bit stall_a = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        a_ready = stall_a ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    byte_q_t         q_a, q_b;
    int              done_cnt_a = 0;
    int              done_cnt_b = 0;
    logic [A_AW-1:0] m_prev_addr  = '0;
    logic            m_prev_valid = 1'b0;
    logic            m_prev_ready = 1'b0;
    logic [7:0]      m_prev_data  = '0;
    bit              m_word_end   = 1'b0;
    int              m_pos        = 0;
    logic [B_AW-1:0] mb_prev_addr = '0;
    bit              mb_wrap      = 1'b0;

    // Monitor A: captures accepted bytes, checks stall stability and address stepping
    always @(negedge clk) begin
        if (rst) begin
            m_prev_addr  = '0;
            m_prev_valid = 1'b0;
            m_word_end   = 1'b0;
            m_pos        = 0;
        end else begin
            if (a_read_addr !== m_prev_addr) begin
                checks++;
                if (!m_word_end) begin
                    errors++;
                    $display("FAIL addr_step: read_addr moved %0d->%0d, required only after a word-end accept",
                             m_prev_addr, a_read_addr);
                end
            end
            if (m_prev_valid && !m_prev_ready) begin
                checks++;
                if (a_tx_valid !== 1'b1 || a_tx_data !== m_prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                             a_tx_valid, a_tx_data, m_prev_data);
                end
            end
            m_word_end = 1'b0;
            if (!a_busy) m_pos = 0;
            if (a_tx_valid && a_ready) begin
                q_a.push_back(a_tx_data);
                m_word_end = (m_pos % BPW == 0);
                m_pos++;
            end
            if (a_done) done_cnt_a++;
            m_prev_addr  = a_read_addr;
            m_prev_valid = a_tx_valid;
            m_prev_ready = a_ready;
            m_prev_data  = a_tx_data;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_tx_valid && b_ready) q_b.push_back(b_tx_data);
            if (b_busy && b_read_addr < mb_prev_addr) mb_wrap = 1'b1;
            if (b_done) done_cnt_b++;
        end
        mb_prev_addr = b_read_addr;
    end

    // ------------------------------------------------------------ reference model
    function automatic byte_q_t model_frame(input word_q_t words);
        byte_q_t    f;
        logic [7:0] x;
        logic [7:0] bt;
        f.push_back(8'hA5);
        x = 8'h00;
        foreach (words[k]) begin
            for (int j = 0; j < BPW; j++) begin
                bt = 8'(words[k] >> (8 * (BPW - 1 - j)));
                f.push_back(bt);
                x = x ^ bt;
            end
        end
        f.push_back(x);
        return f;
    endfunction

    function automatic word_q_t words_a();
        word_q_t w;
        for (int k = 0; k < A_DEPTH; k++) w.push_back(mem_a[k]);
        return w;
    endfunction

    function automatic word_q_t words_b();
        word_q_t w;
        for (int k = 0; k < B_DEPTH; k++) w.push_back(mem_b[k]);
        return w;
    endfunction

    function automatic int first_diff(input byte_q_t got, input byte_q_t exp);
        for (int i = 0; i < exp.size(); i++)
            if (i >= got.size() || got[i] !== exp[i]) return i;
        if (got.size() > exp.size()) return exp.size();
        return -1;
    endfunction

    function automatic logic [7:0] byte_at(input byte_q_t q, input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 8'hxx;
    endfunction

    // mode 0: {16{10+k}}, 1: distinct bytes, 2: random
    task automatic fill_a(input int mode);
        for (int k = 0; k < A_DEPTH; k++) begin
            for (int j = 0; j < BPW; j++) begin
                case (mode)
                    0:       mem_a[k][DW-1-8*j -: 8] = 8'(8'h10 + k);
                    1:       mem_a[k][DW-1-8*j -: 8] = 8'(k * BPW + j);
                    default: mem_a[k][DW-1-8*j -: 8] = 8'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    task automatic run_frame_a(input bit stall, output int cycles, output bit busy_ok, output bit fin);
        stall_a = stall;
        q_a.delete();
        cycles  = 0;
        busy_ok = 1'b1;
        fin     = 1'b0;
        @(posedge clk); #1;
        a_capture_done = 1'b1;
        a_start        = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        for (int i = 0; i < 4000 && !fin; i++) begin
            @(negedge clk);
            if (a_done) fin = 1'b1;
            else begin
                cycles++;
                if (!a_busy) busy_ok = 1'b0;
            end
        end
        stall_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_read_addr !== '0)   begin errors++; $display("FAIL rst_addr: got %h, required 0", a_read_addr); end
        checks++; if (a_tx_data !== 8'h00)  begin errors++; $display("FAIL rst_data: got %h, required 00", a_tx_data); end
        checks++; if (a_tx_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b, required 0", a_tx_valid); end
        checks++; if (a_busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b, required 0", a_busy); end
        checks++; if (a_done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b, required 0", a_done); end
        checks++; if (b_tx_valid !== 1'b0)  begin errors++; $display("FAIL rst_b_valid: got %b, required 0", b_tx_valid); end
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        int cyc, d, dc;
        bit busy_ok, fin;
        byte_q_t exp;
        fill_a(0);
        exp = model_frame(words_a());
        dc  = done_cnt_a;
        run_frame_a(1'b0, cyc, busy_ok, fin);
        d = first_diff(q_a, exp);
        checks++; if (!fin) begin errors++; $display("FAIL t1_timeout: done not seen, required within 4000 cycles"); end
        checks++; if (q_a.size() != 66) begin errors++; $display("FAIL t1_len: got %0d bytes, required 66", q_a.size()); end
        checks++; if (d >= 0) begin errors++; $display("FAIL t1_bytes: byte %0d got %h, required %h", d, byte_at(q_a, d), byte_at(exp, d)); end
        checks++; if (byte_at(q_a, 65) !== 8'h00) begin errors++; $display("FAIL t1_trailer: got %h, required 00", byte_at(q_a, 65)); end
        checks++; if (done_cnt_a - dc != 1) begin errors++; $display("FAIL t1_done: got %0d pulses, required 1", done_cnt_a - dc); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL t1_busy: busy dropped mid-frame, required high"); end
        checks++; if (cyc != 2 + A_DEPTH * (A_RL + BPW)) begin
            errors++; $display("FAIL t1_cycles: got %0d, required %0d", cyc, 2 + A_DEPTH * (A_RL + BPW));
        end
    endtask

    task automatic test_backpressure();
        int cyc, d, dc;
        bit busy_ok, fin;
        byte_q_t exp;
        for (int r = 0; r < 2; r++) begin
            fill_a(r == 0 ? 0 : 2);
            exp = model_frame(words_a());
            dc  = done_cnt_a;
            run_frame_a(1'b1, cyc, busy_ok, fin);
            d = first_diff(q_a, exp);
            checks++; if (!fin) begin errors++; $display("FAIL t2_timeout: run %0d done not seen", r); end
            checks++; if (d >= 0) begin errors++; $display("FAIL t2_bytes: run %0d byte %0d got %h, required %h", r, d, byte_at(q_a, d), byte_at(exp, d)); end
            checks++; if (done_cnt_a - dc != 1) begin errors++; $display("FAIL t2_done: got %0d pulses, required 1", done_cnt_a - dc); end
        end
    endtask

    task automatic test_start_filter();
        int dc, d, n;
        bit quiet, fin;
        byte_q_t exp;
        quiet = 1'b1;
        fin   = 1'b0;
        n     = 0;
        a_capture_done = 1'b0;
        dc = done_cnt_a;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (a_tx_valid !== 1'b0 || a_busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL t3_no_capture: valid/busy rose, required both 0"); end

        fill_a(2);
        exp = model_frame(words_a());
        q_a.delete();
        a_capture_done = 1'b1;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        while (!fin && n < 4000) begin
            @(negedge clk);
            n++;
            a_start        = (n == 10 || n == 30 || n == 55);
            a_capture_done = !(n >= 60 && n < 70);
            if (a_done) begin
                fin            = 1'b1;
                a_start        = 1'b1;
                a_capture_done = 1'b1;
            end
        end
        @(negedge clk);
        a_start = 1'b0;
        repeat (10) @(negedge clk);
        d = first_diff(q_a, exp);
        checks++; if (!fin) begin errors++; $display("FAIL t3_timeout: done not seen"); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL t3_busy: got %b after done-cycle start, required 0", a_busy); end
        checks++; if (done_cnt_a - dc != 1) begin errors++; $display("FAIL t3_done: got %0d pulses, required 1", done_cnt_a - dc); end
        checks++; if (d >= 0) begin errors++; $display("FAIL t3_bytes: byte %0d got %h, required %h", d, byte_at(q_a, d), byte_at(exp, d)); end
    endtask

    task automatic test_mid_reset();
        int n, cyc, d, dc;
        bit busy_ok, fin;
        byte_q_t exp;
        n = 0;
        fill_a(2);
        q_a.delete();
        dc = done_cnt_a;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        while (q_a.size() < 20 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (q_a.size() < 20) begin errors++; $display("FAIL t4_timeout: got %0d bytes, required 20", q_a.size()); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_tx_valid !== 1'b0) begin errors++; $display("FAIL t4_valid: got %b, required 0", a_tx_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL t4_busy: got %b, required 0", a_busy); end
        checks++; if (a_read_addr !== '0) begin errors++; $display("FAIL t4_addr: got %0d, required 0", a_read_addr); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (done_cnt_a != dc) begin errors++; $display("FAIL t4_no_done: got %0d pulses, required 0", done_cnt_a - dc); end

        exp = model_frame(words_a());
        run_frame_a(1'b1, cyc, busy_ok, fin);
        d = first_diff(q_a, exp);
        checks++; if (!fin || d >= 0) begin
            errors++; $display("FAIL t4_refresh: fin=%b byte %0d got %h, required %h", fin, d, byte_at(q_a, d), byte_at(exp, d));
        end
    endtask

    task automatic test_read_latency();
        int cyc, d;
        bit busy_ok, fin;
        byte_q_t exp;
        logic [7:0] x;
        fill_a(1);
        exp = model_frame(words_a());
        x = 8'h00;
        for (int k = 0; k < A_DEPTH * BPW; k++) x = x ^ 8'(k);
        run_frame_a(1'b0, cyc, busy_ok, fin);
        d = first_diff(q_a, exp);
        checks++; if (!fin) begin errors++; $display("FAIL t5_timeout: done not seen"); end
        checks++; if (d >= 0) begin errors++; $display("FAIL t5_bytes: byte %0d got %h, required %h", d, byte_at(q_a, d), byte_at(exp, d)); end
        checks++; if (byte_at(q_a, 65) !== x) begin errors++; $display("FAIL t5_checksum: got %h, required %h", byte_at(q_a, 65), x); end
    endtask

    task automatic test_full_depth();
        int cyc, d;
        bit fin;
        byte_q_t exp;
        cyc = 0;
        fin = 1'b0;
        for (int k = 0; k < B_DEPTH; k++) mem_b[k] = {$urandom, $urandom, $urandom, $urandom};
        exp = model_frame(words_b());
        q_b.delete();
        mb_wrap = 1'b0;
        @(posedge clk); #1;
        b_capture_done = 1'b1;
        b_start        = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        for (int i = 0; i < 20000 && !fin; i++) begin
            @(negedge clk);
            if (b_done) fin = 1'b1;
            else cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        d = first_diff(q_b, exp);
        checks++; if (!fin) begin errors++; $display("FAIL t6_timeout: done not seen"); end
        checks++; if (q_b.size() != 8194) begin errors++; $display("FAIL t6_len: got %0d bytes, required 8194", q_b.size()); end
        checks++; if (d >= 0) begin errors++; $display("FAIL t6_bytes: byte %0d got %h, required %h", d, byte_at(q_b, d), byte_at(exp, d)); end
        checks++; if (b_read_addr !== 9'd511) begin errors++; $display("FAIL t6_last_addr: got %0d, required 511", b_read_addr); end
        checks++; if (mb_wrap) begin errors++; $display("FAIL t6_wrap: read_addr went backwards, required monotonic"); end
        checks++; if (cyc != 2 + B_DEPTH * (B_RL + BPW)) begin
            errors++; $display("FAIL t6_cycles: got %0d, required %0d", cyc, 2 + B_DEPTH * (B_RL + BPW));
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_start_filter();
        test_mid_reset();
        test_read_latency();
        test_full_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
